network_mul_share_sched: RTL
============================

Name: network_mul_share_sched

Overview:
- Round-robin scheduler that time-shares one 16-bit signed × 14-bit unsigned multiplier (30-bit product) between NUM_REQ requesters. These are layer engines that would otherwise each instantiate their own DSP48 multiplier.
- Accepts one operand pair per cycle via valid/ready, pipelines it through the shared multiplier, and returns the product tagged with the requester ID on one backpressured result channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of result tag; must satisfy 2**ID_W >= NUM_REQ.
- FRAC_BITS, 13, right-shift applied before saturation; used only with NETWORK_MUL_SAT_EN.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_din0  in  NUM_REQ*16  signed operand a, requester i at bits [16i+15:16i].
- req_din1  in  NUM_REQ*14  unsigned operand b, requester i at bits [14i+13:14i].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_dout  out  30  signed product (or saturated value, see feature).
- out_id  out  ID_W  index of requester that issued the operands.
- busy  out  1  high when any pipeline stage holds data.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge):
  - s1_valid=0, out_valid=0, out_dout=0, out_id=0.
  - RR pointer=0, busy=0. req_ready is combinationally 0 while ap_rst_n=0.
  - Reset mid-operation discards all in-flight operands. No result is emitted for them.
- Pipeline enable: adv = !out_valid || out_ready.
- Stage 0, arbitration (combinational):
  - When adv=1, grant the first requester with req_valid=1, searching upward from the RR pointer and wrapping at NUM_REQ-1 → 0.
  - req_ready[g]=1 for the granted requester only. All req_ready=0 when adv=0.
  - A transfer occurs on req_valid[i] && req_ready[i].
- Stage 1 register:
  - On adv, s1_valid <= any grant. s1_a, s1_b, s1_id <= operands and index of the granted requester.
  - RR pointer <= (g+1) mod NUM_REQ, only when a grant occurs. Otherwise the pointer holds.
- Multiplier: p = $signed(s1_a) * $signed({1'b0, s1_b}). Full 30-bit signed result, no truncation.
- Stage 2 output register:
  - On adv: out_valid <= s1_valid. If s1_valid, out_dout <= p and out_id <= s1_id.
  - While out_valid && !out_ready, out_valid, out_dout and out_id hold stable.
  - When s1_valid=0, out_dout/out_id are don't-change (hold).
- Latency and throughput:
  - Accept edge to out_valid is exactly 2 cycles with no backpressure.
  - Throughput is 1 result per cycle.
- Backpressure:
  - When out_ready=0 with out_valid=1, the whole pipeline freezes. No grants, s1 holds.
  - No data is lost or duplicated. Max in-flight results = 2.
- Simultaneous events:
  - Result handshake and new grant in the same cycle is legal (adv=1 via out_ready).
  - All requesters valid → strict rotation 0,1,2,3,0…
  - A single requester valid continuously → granted every cycle.
- Requesters must hold req_valid and operands stable until accepted. The scheduler does not check this.
- busy = s1_valid || out_valid.

Optional Feature:
- Macro: NETWORK_MUL_SAT_EN.
- Defined:
  - Stage 2 captures sat16(p >>> FRAC_BITS), sign-extended to 30 bits. The shift is arithmetic.
  - sat16 clamps to [-32768, 32767].
  - Latency is unchanged.
- Undefined: out_dout is the raw 30-bit product and FRAC_BITS is unused.

Test Plan:
- Single op: req0 a=-3, b=5, out_ready=1 → 2 cycles later out_valid=1, out_dout=30'h3FFFFFF1 (-15), out_id=0.
- Extremes:
  - a=-32768, b=16383 → out_dout=-536838144.
  - a=32767, b=16383 → 536821761.
  - With NETWORK_MUL_SAT_EN and FRAC_BITS=13, the second case gives 32767 and the first gives -32768.
- Round-robin: all 4 requesters valid for 8 cycles with distinct operands → out_id sequence 0,1,2,3,0,1,2,3. Each out_dout matches a*b of that requester's operands.
- Backpressure:
  - Stream on req2, out_ready=0 for 5 cycles mid-stream → all req_ready=0 during the stall. out_dout/out_id stay stable.
  - After release, every accepted operand pair yields exactly one result, in order.
- Pointer wrap: only req3 and req1 valid, pointer at 2 → grant order 3,1,3,1. Pointer stays put on idle cycles.
- Reset mid-operation: ap_rst_n=0 for 1 cycle with both stages full → next cycle out_valid=0, busy=0, and no stale result appears afterwards.

Source files
------------

// File: rtl/network_mul_share_sched.sv
// Round-robin scheduler time-sharing one 16x14 signed multiplier among NUM_REQ requesters.
// Define NETWORK_MUL_SAT_EN to return sat16(product >>> FRAC_BITS) instead of the raw product.
module network_mul_share_sched #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int FRAC_BITS = 13
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_din0,
    input  logic [NUM_REQ*14-1:0] req_din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [29:0]           out_dout,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy
);
    if ((2 ** ID_W) < NUM_REQ || NUM_REQ < 2 || NUM_REQ > 8 ||
        FRAC_BITS < 0 || FRAC_BITS > 29) begin : g_bad_cfg
        $error("network_mul_share_sched: illegal parameter set");
    end

    logic               adv;
    logic               gnt_any;
    int                 gnt_idx;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               s1_valid_q, s1_valid_d;
    logic [15:0]        s1_a_q, s1_a_d;
    logic [13:0]        s1_b_q, s1_b_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               out_valid_q, out_valid_d;
    logic [29:0]        out_dout_q, out_dout_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic signed [29:0] prod;
    logic [29:0]        res;

    // A stalled output register freezes the whole pipe, including arbitration.
    assign adv = !out_valid_q || out_ready;

    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_any && req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = j;
            end
        end
        gnt_any = gnt_any && adv && ap_rst_n;
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign prod = $signed({{14{s1_a_q[15]}}, s1_a_q}) * $signed({16'b0, s1_b_q});

`ifdef NETWORK_MUL_SAT_EN
    logic signed [29:0] shifted;
    assign shifted = prod >>> FRAC_BITS;
    always_comb begin
        if (shifted > 30'sd32767) begin
            res = 30'h0000_7FFF;
        end else if (shifted < -30'sd32768) begin
            res = 30'h3FFF_8000;
        end else begin
            res = shifted;
        end
    end
`else
    assign res = prod;
`endif

    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        out_valid_d = out_valid_q;
        out_dout_d  = out_dout_q;
        out_id_d    = out_id_q;
        if (adv) begin
            s1_valid_d  = gnt_any;
            out_valid_d = s1_valid_q;
            if (gnt_any) begin
                s1_a_d  = req_din0[16*gnt_idx +: 16];
                s1_b_d  = req_din1[14*gnt_idx +: 14];
                s1_id_d = ID_W'(gnt_idx);
                ptr_d   = (gnt_idx == NUM_REQ - 1) ? '0 : ID_W'(gnt_idx + 1);
            end
            if (s1_valid_q) begin
                out_dout_d = res;
                out_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            out_valid_q <= 1'b0;
            out_dout_q  <= '0;
            out_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            out_valid_q <= out_valid_d;
            out_dout_q  <= out_dout_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_dout  = out_dout_q;
    assign out_id    = out_id_q;
    assign busy      = s1_valid_q || out_valid_q;

endmodule
